// File: rtl/bramac_pkg.sv
// Shared definitions for the BrAMAC instruction sequencer: word layout,
// precision encodings, sequencer state encoding and small helpers.
package bramac_pkg;

  localparam int DWIDTH     = 40;
  localparam int ACT_W      = 8;
  localparam int ROW_W      = 7;
  localparam int COL_W      = 2;
  localparam int LEN_W      = 5;
  localparam int K_W        = 4;
  localparam int RUN_W      = 4;
  localparam int MAX_LEN    = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_WIDTH = 2 * ACT_W;

  // Instruction word bit offsets
  localparam int F_DUMMY    = 39;
  localparam int F_I2_LSB   = 31;
  localparam int F_I1_LSB   = 23;
  localparam int F_COL_LSB  = 21;
  localparam int F_ROW2_LSB = 14;
  localparam int F_ROW1_LSB = 7;
  localparam int F_DONE     = 6;
  localparam int F_COPY     = 5;
  localparam int F_START    = 4;
  localparam int F_RESET    = 3;
  localparam int F_INTYPE   = 2;
  localparam int F_PREC_LSB = 0;

  // Precision encodings
  localparam logic [1:0] PREC_NONE = 2'b00;
  localparam logic [1:0] PREC_2B   = 2'b01;
  localparam logic [1:0] PREC_4B   = 2'b10;
  localparam logic [1:0] PREC_8B   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WAIT_ACT = 4'd1,
    S_RST      = 4'd2,
    S_START    = 4'd3,
    S_INIT     = 4'd4,
    S_COPY     = 4'd5,
    S_RUN      = 4'd6,
    S_ACC      = 4'd7,
    S_DONE1    = 4'd8,
    S_DONE2    = 4'd9,
    S_CLR      = 4'd10
  } seq_state_e;

  // Last value of the RUN counter: RUN lasts P+2 cycles, counter runs 0..P+1
  function automatic logic [RUN_W-1:0] run_last(input logic [1:0] prec);
    case (prec)
      PREC_2B: run_last = 4'd3;
      PREC_4B: run_last = 4'd5;
      PREC_8B: run_last = 4'd9;
      default: run_last = 4'd9;
    endcase
  endfunction

  // BRAM is in compute mode in every state from RST through CLR
  function automatic logic in_compute(input seq_state_e s);
    in_compute = !((s == S_IDLE) || (s == S_WAIT_ACT));
  endfunction

endpackage

// File: rtl/bramac_act_fifo.sv
// Activation-pair FIFO. Show-ahead read port: rdata is the head entry
// whenever the FIFO is non-empty. Push and pop may occur in the same cycle.
module bramac_act_fifo
  import bramac_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array: written on accepted push only, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bramac_inst_seq.sv
// BrAMAC instruction sequencer. Accepts a command and a stream of activation
// pairs, and emits one 40-bit instruction word per cycle to the 1DA FSM:
// RST, START, INIT, then per pair COPY / RUN x(P+2) / ACC, then DONE1,
// DONE2, CLR. The instruction register is loaded from the next state, so the
// word on inst in a cycle always belongs to the state held in that cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid may be raised without waiting for ready, and ready never
// depends combinationally on valid.
module bramac_inst_seq
  import bramac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_prec,
  input  logic              cmd_intype,
  input  logic [4:0]        cmd_len,
  input  logic [6:0]        cmd_row1,
  input  logic [6:0]        cmd_row2,
  input  logic [1:0]        cmd_col,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [7:0]        act_in1,
  input  logic [7:0]        act_in2,
  output logic [39:0]       inst,
  output logic              comp_en,
  output logic              busy,
  output logic              result_strobe,
  output logic              cmd_err
);

  seq_state_e             state_q;
  seq_state_e             state_d;
  logic [K_W-1:0]         k_q;
  logic [K_W-1:0]         k_d;
  logic [RUN_W-1:0]       run_q;
  logic [RUN_W-1:0]       run_d;

  logic [1:0]             prec_q;
  logic                   intype_q;
  logic [LEN_W-1:0]       len_q;
  logic [ROW_W-1:0]       row1_q;
  logic [ROW_W-1:0]       row2_q;
  logic [COL_W-1:0]       col_q;

  logic [DWIDTH-1:0]      inst_d;
  logic                   err_d;
  logic                   cmd_fire;
  logic                   more_pairs;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic [FIFO_WIDTH-1:0]  fifo_rdata;
  logic [LEN_W-1:0]       fifo_count;
  logic                   fifo_full;

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign act_ready  = !fifo_full;
  assign fifo_push  = act_valid && act_ready;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign more_pairs = ({1'b0, k_q} + 5'd1) < len_q;

  bramac_act_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_act_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({act_in2, act_in1}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // Next-state, pair index, RUN counter and FIFO pop decisions
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    run_d    = run_q;
    err_d    = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          if ((cmd_prec == PREC_NONE) || (cmd_len > 5'(MAX_LEN))) begin
            err_d = 1'b1;
          end else if (cmd_len != '0) begin
            state_d = S_WAIT_ACT;
          end
        end
      end
      S_WAIT_ACT: begin
        if (fifo_count >= len_q) begin
          state_d = S_RST;
        end
      end
      S_RST: begin
        state_d = S_START;
      end
      S_START: begin
        state_d  = S_INIT;
        fifo_pop = 1'b1;
      end
      S_INIT: begin
        state_d = S_COPY;
        k_d     = '0;
      end
      S_COPY: begin
        state_d = S_RUN;
        run_d   = '0;
      end
      S_RUN: begin
        if (run_q == run_last(prec_q)) begin
          state_d  = S_ACC;
          fifo_pop = more_pairs;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      S_ACC: begin
        if (more_pairs) begin
          state_d = S_COPY;
          k_d     = k_q + 1'b1;
        end else begin
          state_d = S_DONE1;
        end
      end
      S_DONE1: begin
        state_d = S_DONE2;
      end
      S_DONE2: begin
        state_d = S_CLR;
      end
      S_CLR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Instruction word for the state being entered
  always_comb begin
    inst_d          = '0;
    inst_d[F_DUMMY] = 1'b0;
    case (state_d)
      S_RST, S_CLR: begin
        inst_d[F_RESET] = 1'b1;
      end
      S_START: begin
        inst_d[F_START] = 1'b1;
      end
      S_INIT: begin
        inst_d[F_I1_LSB +: ACT_W]   = fifo_rdata[ACT_W-1:0];
        inst_d[F_I2_LSB +: ACT_W]   = fifo_rdata[FIFO_WIDTH-1:ACT_W];
        inst_d[F_INTYPE]            = intype_q;
        inst_d[F_PREC_LSB +: 2]     = prec_q;
      end
      S_COPY: begin
        inst_d[F_COPY]              = 1'b1;
        inst_d[F_ROW1_LSB +: ROW_W] = row1_q + {3'b000, k_d};
        inst_d[F_ROW2_LSB +: ROW_W] = row2_q + {3'b000, k_d};
        inst_d[F_COL_LSB +: COL_W]  = col_q;
      end
      S_ACC: begin
        if (fifo_pop) begin
          inst_d[F_I1_LSB +: ACT_W] = fifo_rdata[ACT_W-1:0];
          inst_d[F_I2_LSB +: ACT_W] = fifo_rdata[FIFO_WIDTH-1:ACT_W];
        end else begin
          inst_d[F_DONE] = 1'b1;
        end
      end
      default: begin
        inst_d = '0;
      end
    endcase
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      run_q         <= '0;
      inst          <= '0;
      comp_en       <= 1'b0;
      result_strobe <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      run_q         <= run_d;
      inst          <= inst_d;
      comp_en       <= in_compute(state_d);
      result_strobe <= (state_d == S_DONE2);
      cmd_err       <= err_d;
    end
  end

  // Command fields are captured only on an accepted command in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prec_q   <= '0;
      intype_q <= 1'b0;
      len_q    <= '0;
      row1_q   <= '0;
      row2_q   <= '0;
      col_q    <= '0;
    end else if (cmd_fire) begin
      prec_q   <= cmd_prec;
      intype_q <= cmd_intype;
      len_q    <= cmd_len;
      row1_q   <= cmd_row1;
      row2_q   <= cmd_row2;
      col_q    <= cmd_col;
    end
  end

endmodule

// File: tb/tb_bramac_inst_seq.sv
// Directed bench for bramac_inst_seq: nominal signed run, row wrap with
// activation starvation, illegal command, FIFO full / simultaneous push-pop,
// reset mid-sequence followed by a clean unsigned 8-bit run.
module tb_bramac_inst_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_prec;
  logic        cmd_intype;
  logic [4:0]  cmd_len;
  logic [6:0]  cmd_row1;
  logic [6:0]  cmd_row2;
  logic [1:0]  cmd_col;
  logic        act_valid;
  logic        act_ready;
  logic [7:0]  act_in1;
  logic [7:0]  act_in2;
  logic [39:0] inst;
  logic        comp_en;
  logic        busy;
  logic        result_strobe;
  logic        cmd_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [39:0] w [0:63];
  int n_w;
  int strobe_cnt;
  int strobe_idx;
  int done_cnt;
  int done_idx;
  logic [39:0] run_or;
  int guard;
  int copies;

  bramac_inst_seq dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_prec      (cmd_prec),
    .cmd_intype    (cmd_intype),
    .cmd_len       (cmd_len),
    .cmd_row1      (cmd_row1),
    .cmd_row2      (cmd_row2),
    .cmd_col       (cmd_col),
    .act_valid     (act_valid),
    .act_ready     (act_ready),
    .act_in1       (act_in1),
    .act_in2       (act_in2),
    .inst          (inst),
    .comp_en       (comp_en),
    .busy          (busy),
    .result_strobe (result_strobe),
    .cmd_err       (cmd_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] mkw(
    input logic [7:0] i2, input logic [7:0] i1, input logic [1:0] col,
    input logic [6:0] r2, input logic [6:0] r1, input logic done,
    input logic copy, input logic start, input logic rst,
    input logic intype, input logic [1:0] prec);
    return {1'b0, i2, i1, col, r2, r1, done, copy, start, rst, intype, prec};
  endfunction

  task automatic push_pair(input logic [7:0] i1, input logic [7:0] i2);
    act_in1   = i1;
    act_in2   = i2;
    act_valid = 1'b1;
    tick();
    act_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] prec, input logic intype, input logic [4:0] len,
                          input logic [6:0] r1, input logic [6:0] r2, input logic [1:0] col);
    cmd_prec   = prec;
    cmd_intype = intype;
    cmd_len    = len;
    cmd_row1   = r1;
    cmd_row2   = r2;
    cmd_col    = col;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Record every word issued while comp_en is high
  task automatic collect(input int max);
    int g;
    g = 0;
    n_w = 0; strobe_cnt = 0; done_cnt = 0; strobe_idx = -1; done_idx = -1;
    while (!comp_en && g < max) begin
      tick();
      g++;
    end
    while (comp_en && g < max) begin
      if (n_w < 64) w[n_w] = inst;
      if (result_strobe) begin strobe_cnt++; strobe_idx = n_w; end
      if (inst[6]) begin done_cnt++; done_idx = n_w; end
      n_w++;
      tick();
      g++;
    end
    n_cmp++;
    assert (g < max) else begin
      n_bad++;
      $error("FAIL collect_timeout: observed %0d cycles expected fewer than %0d", g, max);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_prec = '0; cmd_intype = 1'b0; cmd_len = '0;
    cmd_row1 = '0; cmd_row2 = '0; cmd_col = '0; act_valid = 1'b0; act_in1 = '0; act_in2 = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_inst", inst, 40'h0);
    chk("rst_comp_en", {39'b0, comp_en}, 40'h0);
    chk("rst_busy", {39'b0, busy}, 40'h0);
    chk("rst_strobe", {39'b0, result_strobe}, 40'h0);
    chk("rst_cmd_err", {39'b0, cmd_err}, 40'h0);
    chk("rst_cmd_ready", {39'b0, cmd_ready}, 40'h1);
    chk("rst_act_ready", {39'b0, act_ready}, 40'h1);

    // Nominal signed 4-bit, 3 pairs
    push_pair(8'h35, 8'hA1);
    push_pair(8'h07, 8'h7F);
    push_pair(8'hFF, 8'h80);
    send_cmd(2'b10, 1'b1, 5'd3, 7'd5, 7'd70, 2'd2);
    collect(200);
    chk("nom_len", 40'(n_w), 40'd30);
    chk("nom_rst", w[0], 40'h8);
    chk("nom_start", w[1], 40'h10);
    chk("nom_init", w[2], mkw(8'hA1, 8'h35, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10));
    chk("nom_copy0", w[3], mkw(8'h00, 8'h00, 2'd2, 7'd70, 7'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    chk("nom_copy1", w[11], mkw(8'h00, 8'h00, 2'd2, 7'd71, 7'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    chk("nom_copy2", w[19], mkw(8'h00, 8'h00, 2'd2, 7'd72, 7'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    run_or = '0;
    for (int i = 4; i <= 9; i++) run_or = run_or | w[i];
    chk("nom_run_zero", run_or, 40'h0);
    chk("nom_acc0", w[10], mkw(8'h7F, 8'h07, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    chk("nom_acc1", w[18], mkw(8'h80, 8'hFF, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    chk("nom_acc2", w[26], 40'h40);
    chk("nom_done_cnt", 40'(done_cnt), 40'd1);
    chk("nom_done_idx", 40'(done_idx), 40'd26);
    chk("nom_strobe_cnt", 40'(strobe_cnt), 40'd1);
    chk("nom_strobe_idx", 40'(strobe_idx), 40'd28);
    chk("nom_done12", w[27] | w[28], 40'h0);
    chk("nom_clr", w[29], 40'h8);
    chk("nom_idle_busy", {39'b0, busy}, 40'h0);

    // Starvation plus row wrap, 2-bit unsigned, len 4
    push_pair(8'h11, 8'h22);
    push_pair(8'h33, 8'h44);
    send_cmd(2'b01, 1'b0, 5'd4, 7'd126, 7'd3, 2'd1);
    tick();
    send_cmd(2'b11, 1'b1, 5'd1, 7'd50, 7'd50, 2'd0);
    tick();
    chk("starve_busy", {39'b0, busy}, 40'h1);
    chk("starve_cmd_ready", {39'b0, cmd_ready}, 40'h0);
    chk("starve_inst", inst, 40'h0);
    chk("starve_comp_en", {39'b0, comp_en}, 40'h0);
    push_pair(8'h55, 8'h66);
    chk("starve3_comp_en", {39'b0, comp_en}, 40'h0);
    push_pair(8'h77, 8'h88);
    chk("starve4_inst", inst, 40'h0);
    chk("starve4_comp_en", {39'b0, comp_en}, 40'h0);
    tick();
    chk("starve_rst_word", inst, 40'h8);
    chk("starve_rst_comp_en", {39'b0, comp_en}, 40'h1);
    collect(200);
    chk("wrap_len", 40'(n_w), 40'd30);
    chk("wrap_init", w[2], mkw(8'h22, 8'h11, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01));
    chk("wrap_row1_k0", 40'(w[3][13:7]), 40'd126);
    chk("wrap_row1_k1", 40'(w[9][13:7]), 40'd127);
    chk("wrap_row1_k2", 40'(w[15][13:7]), 40'd0);
    chk("wrap_row1_k3", 40'(w[21][13:7]), 40'd1);
    chk("wrap_copy2", w[15], mkw(8'h00, 8'h00, 2'd1, 7'd5, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    chk("wrap_acc2", w[20], mkw(8'h88, 8'h77, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    chk("wrap_acc3", w[26], 40'h40);
    chk("wrap_strobe_idx", 40'(strobe_idx), 40'd28);

    // Illegal precision and zero length
    send_cmd(2'b00, 1'b1, 5'd3, 7'd1, 7'd2, 2'd0);
    chk("ill_err", {39'b0, cmd_err}, 40'h1);
    chk("ill_inst", inst, 40'h0);
    chk("ill_busy", {39'b0, busy}, 40'h0);
    tick();
    chk("ill_err_pulse", {39'b0, cmd_err}, 40'h0);
    send_cmd(2'b10, 1'b0, 5'd0, 7'd1, 7'd2, 2'd0);
    chk("len0_busy", {39'b0, busy}, 40'h0);
    chk("len0_err", {39'b0, cmd_err}, 40'h0);

    // FIFO: 15 queued, pop and push on the same edge, then full
    for (int i = 0; i < 15; i++) push_pair(8'(i), 8'(8'hC0 + i));
    chk("fifo15_ready", {39'b0, act_ready}, 40'h1);
    send_cmd(2'b01, 1'b1, 5'd2, 7'd10, 7'd20, 2'd3);
    tick();
    chk("fifo_rst_word", inst, 40'h8);
    tick();
    chk("fifo_start_word", inst, 40'h10);
    act_in1 = 8'hAB; act_in2 = 8'hCD; act_valid = 1'b1;
    tick();
    chk("fifo_init_word", inst, mkw(8'hC0, 8'h00, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01));
    chk("fifo_popush_ready", {39'b0, act_ready}, 40'h1);
    act_in1 = 8'hBA; act_in2 = 8'hDC;
    tick();
    act_valid = 1'b0;
    chk("fifo_full_ready", {39'b0, act_ready}, 40'h0);
    guard = 0;
    while (busy && guard < 100) begin tick(); guard++; end
    chk("fifo_seq_end", {39'b0, busy}, 40'h0);

    // Reset during RUN of pair 1
    send_cmd(2'b11, 1'b0, 5'd2, 7'd0, 7'd0, 2'd0);
    copies = 0; guard = 0;
    while (copies < 2 && guard < 200) begin
      tick();
      guard++;
      if (inst[5]) copies++;
    end
    chk("mid_second_copy", 40'(copies), 40'd2);
    tick();
    tick();
    chk("mid_in_run_inst", inst, 40'h0);
    chk("mid_in_run_comp_en", {39'b0, comp_en}, 40'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_inst", inst, 40'h0);
    chk("mid_rst_comp_en", {39'b0, comp_en}, 40'h0);
    chk("mid_rst_busy", {39'b0, busy}, 40'h0);
    chk("mid_rst_cmd_ready", {39'b0, cmd_ready}, 40'h1);
    chk("mid_rst_act_ready", {39'b0, act_ready}, 40'h1);
    tick();
    reset = 1'b0;
    tick();

    // Clean unsigned 8-bit single pair after reset
    push_pair(8'h5A, 8'hC3);
    send_cmd(2'b11, 1'b0, 5'd1, 7'd9, 7'd9, 2'd0);
    collect(100);
    chk("u8_len", 40'(n_w), 40'd18);
    chk("u8_init", w[2], mkw(8'hC3, 8'h5A, 2'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11));
    chk("u8_copy", w[3], mkw(8'h00, 8'h00, 2'd0, 7'd9, 7'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    run_or = '0;
    for (int i = 4; i <= 13; i++) run_or = run_or | w[i];
    chk("u8_run_zero", run_or, 40'h0);
    chk("u8_acc", w[14], 40'h0000000040);
    chk("u8_strobe_idx", 40'(strobe_idx), 40'd16);
    chk("u8_clr", w[17], 40'h8);

    // FIFO should now be empty: a len-1 command must wait
    send_cmd(2'b01, 1'b0, 5'd1, 7'd0, 7'd0, 2'd0);
    repeat (3) tick();
    chk("empty_wait_busy", {39'b0, busy}, 40'h1);
    chk("empty_wait_comp_en", {39'b0, comp_en}, 40'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
